// File: rtl/memory_master_pkg.sv
// Shared constants and FSM state encoding for the burst memory initiator.
// Build option: MEMORY_MASTER_VERIFY_EN adds the write read-back states.
package memory_master_pkg;

    localparam int MEM_DEPTH  = 17;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        IDLE,
        WR_DATA,
        WR_REQ,
`ifdef MEMORY_MASTER_VERIFY_EN
        VFY_REQ,
        VFY_CHK,
`endif
        RD_REQ,
        RD_WAIT,
        RD_RESP,
        DONE
    } mm_state_e;

endpackage

// File: rtl/mem_burst_counter.sv
// Burst address register (wraps at the last word) and remaining-beat
// down-counter, with start-address range check and length saturation.
module mem_burst_counter
    import memory_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [ADDR_WIDTH-1:0] cmd_length,
    output logic                  addr_oob,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    function automatic logic [ADDR_WIDTH-1:0] sat_length(input logic [ADDR_WIDTH-1:0] len);
        return (len > LAST_ADDR) ? LAST_ADDR : len;
    endfunction

    assign addr_oob = (cmd_address > LAST_ADDR);
    assign address  = addr_q;
    assign last     = (cnt_q == '0);

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = cmd_address;
            cnt_d  = sat_length(cmd_length);
        end else if (step) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            if (!last) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_master.sv
// Burst read/write initiator for the single-port byte memory.
// Build option: MEMORY_MASTER_VERIFY_EN enables read-back verify of every write beat.
module memory_master
    import memory_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdWrite,
    input  logic [ADDR_WIDTH-1:0] CmdAddress,
    input  logic [ADDR_WIDTH-1:0] CmdLength,
    input  logic                  WrValid,
    output logic                  WrReady,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  RdValid,
    input  logic                  RdReady,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Done,
    output logic                  AddrError,
    output logic                  VerifyError,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemReadOrWrite,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    mm_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_rw_q, mem_rw_d;
    logic                  done_q, done_d;
    logic                  aerr_q, aerr_d;
    logic                  load, step, addr_oob, last;

    mem_burst_counter u_counter (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .cmd_address (CmdAddress),
        .cmd_length  (CmdLength),
        .addr_oob    (addr_oob),
        .address     (MemAddress),
        .last        (last)
    );

`ifdef MEMORY_MASTER_VERIFY_EN
    logic verr_q, verr_d;
    assign VerifyError = verr_q;
`else
    assign VerifyError = 1'b0;
`endif

    assign CmdReady       = (state_q == IDLE);
    assign WrReady        = (state_q == WR_DATA);
    assign RdValid        = (state_q == RD_RESP);
    assign RdData         = rdata_q;
    assign Done           = done_q;
    assign AddrError      = aerr_q;
    assign MemWriteData   = wdata_q;
    assign MemReadOrWrite = mem_rw_q;

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        aerr_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
`ifdef MEMORY_MASTER_VERIFY_EN
        verr_d  = verr_q;
`endif
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
`ifdef MEMORY_MASTER_VERIFY_EN
                    verr_d = 1'b0;
`endif
                    if (addr_oob) begin
                        aerr_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = CmdWrite ? WR_DATA : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (WrValid) begin
                    wdata_d = WrData;
                    state_d = WR_REQ;
                end
            end
`ifdef MEMORY_MASTER_VERIFY_EN
            WR_REQ:  state_d = VFY_REQ;
            VFY_REQ: state_d = VFY_CHK;
            VFY_CHK: begin
                if (MemReadData != wdata_q) begin
                    verr_d = 1'b1;
                end
                step    = 1'b1;
                state_d = last ? DONE : WR_DATA;
            end
`else
            WR_REQ: begin
                step    = 1'b1;
                state_d = last ? DONE : WR_DATA;
            end
`endif
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                rdata_d = MemReadData;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (RdReady) begin
                    step    = 1'b1;
                    state_d = last ? DONE : RD_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes are decoded from the next state so they are flop outputs aligned with their state.
        mem_rw_d = (state_d == WR_REQ);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_rw_q <= 1'b0;
            done_q   <= 1'b0;
            aerr_q   <= 1'b0;
`ifdef MEMORY_MASTER_VERIFY_EN
            verr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mem_rw_q <= mem_rw_d;
            done_q   <= done_d;
            aerr_q   <= aerr_d;
`ifdef MEMORY_MASTER_VERIFY_EN
            verr_q   <= verr_d;
`endif
        end
    end

endmodule

// File: tb/tb_memory_master.sv
// Directed bench for memory_master with a behavioural synchronous-read memory
// and a read-beat scoreboard checked by an independent monitor.
module tb_memory_master;
    import memory_master_pkg::*;

`ifdef MEMORY_MASTER_VERIFY_EN
    localparam int WR_CYC  = 4;
    localparam int VFY_EXP = 1;
`else
    localparam int WR_CYC  = 2;
    localparam int VFY_EXP = 0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  CmdValid, CmdReady, CmdWrite;
    logic [ADDR_WIDTH-1:0] CmdAddress, CmdLength;
    logic                  WrValid, WrReady;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  RdValid, RdReady;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  Done, AddrError, VerifyError;
    logic [DATA_WIDTH-1:0] MemWriteData, MemReadData;
    logic [ADDR_WIDTH-1:0] MemAddress;
    logic                  MemReadOrWrite;

    logic [7:0] mem [0:31];
    logic       corrupt = 1'b0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    int         aerr_cnt = 0;
    int         wstb_cnt = 0;
    logic [7:0] exp_rd [$];
    logic [7:0] wq [$];

    memory_master dut (
        .clk            (clk),
        .reset          (reset),
        .CmdValid       (CmdValid),
        .CmdReady       (CmdReady),
        .CmdWrite       (CmdWrite),
        .CmdAddress     (CmdAddress),
        .CmdLength      (CmdLength),
        .WrValid        (WrValid),
        .WrReady        (WrReady),
        .WrData         (WrData),
        .RdValid        (RdValid),
        .RdReady        (RdReady),
        .RdData         (RdData),
        .Done           (Done),
        .AddrError      (AddrError),
        .VerifyError    (VerifyError),
        .MemWriteData   (MemWriteData),
        .MemAddress     (MemAddress),
        .MemReadOrWrite (MemReadOrWrite),
        .MemReadData    (MemReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: write at the closing edge of a write cycle, registered read; address 7 can be forced bad.
    always @(posedge clk) begin
        if (MemReadOrWrite)
            mem[MemAddress] <= (corrupt && MemAddress == 5'd7) ? ~MemWriteData : MemWriteData;
        MemReadData <= mem[MemAddress];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within the cycle budget, required a response", name);
    endtask

    // Monitor: counts strobes and scores every read beat presented.
    initial begin
        forever begin
            @(negedge clk);
            if (Done) done_cnt++;
            if (AddrError) aerr_cnt++;
            if (MemReadOrWrite) wstb_cnt++;
            if (RdValid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got beat 0x%0h, required no beat", RdData);
                end else begin
                    chk("rd_data", RdData, exp_rd[0]);
                    if (RdReady) void'(exp_rd.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic wr, input int addr, input int len);
        int g;
        CmdValid   = 1'b1;
        CmdWrite   = wr;
        CmdAddress = ADDR_WIDTH'(addr);
        CmdLength  = ADDR_WIDTH'(len);
        g = 0;
        while (!CmdReady && g < 200) begin tick(); g++; end
        if (!CmdReady) timeout("cmd_accept");
        tick();
        acc_cyc  = cyc;
        CmdValid = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len);
        int g;
        issue(1'b1, addr, len);
        for (int i = 0; i < wq.size(); i++) begin
            WrValid = 1'b1;
            WrData  = wq[i];
            g = 0;
            while (!WrReady && g < 50) begin tick(); g++; end
            if (!WrReady) begin
                timeout("wr_beat");
                break;
            end
            tick();
        end
        WrValid = 1'b0;
    endtask

    task automatic read_burst(input int addr, input int len, input int stall_beat, input int stall_cyc);
        int g;
        RdReady = 1'b1;
        issue(1'b0, addr, len);
        for (int b = 0; b <= len; b++) begin
            g = 0;
            while (!RdValid && g < 50) begin tick(); g++; end
            if (!RdValid) begin
                timeout("rd_beat");
                break;
            end
            if (b == 0) chk("rd_first_latency", cyc - acc_cyc, 2);
            if (b == stall_beat) begin
                RdReady = 1'b0;
                repeat (stall_cyc) tick();
                RdReady = 1'b1;
            end
            tick();
        end
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int g, d0;
        d0 = done_cnt;
        g  = 0;
        while (!Done && g < 400) begin tick(); g++; end
        if (!Done) begin
            timeout({name, "_done"});
        end else begin
            chk({name, "_latency"}, cyc - acc_cyc, exp_cycles);
            chk({name, "_cmdready_in_done"}, CmdReady, 0);
            tick();
            chk({name, "_cmdready_after"}, CmdReady, 1);
            chk({name, "_done_one_pulse"}, done_cnt - d0, 1);
        end
    endtask

    initial begin
        int d0, a0, w0;
        reset = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b0; CmdAddress = '0; CmdLength = '0;
        WrValid = 1'b0; WrData = '0; RdReady = 1'b0;
        tick(); tick();
        chk("rst_cmdready", CmdReady, 1);
        chk("rst_wrready", WrReady, 0);
        chk("rst_rdvalid", RdValid, 0);
        chk("rst_mem_rw", MemReadOrWrite, 0);
        chk("rst_mem_addr", MemAddress, 0);
        chk("rst_mem_wdata", MemWriteData, 0);
        chk("rst_rddata", RdData, 0);
        chk("rst_done", Done, 0);
        chk("rst_addrerr", AddrError, 0);
        chk("rst_verr", VerifyError, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_cmdready", CmdReady, 1);

        wq = '{8'hA1, 8'hB2, 8'hC3};
        write_burst(3, 2);
        wait_done("wr", 3 * WR_CYC);
        chk("mem3", mem[3], 8'hA1);
        chk("mem4", mem[4], 8'hB2);
        chk("mem5", mem[5], 8'hC3);

        exp_rd.push_back(8'hA1); exp_rd.push_back(8'hB2); exp_rd.push_back(8'hC3);
        read_burst(3, 2, 1, 2);
        wait_done("rd", 3 * 3 + 2);

        wq = '{8'h11, 8'h22};
        write_burst(16, 1);
        wait_done("wrap", 2 * WR_CYC);
        chk("mem16", mem[16], 8'h11);
        chk("mem0", mem[0], 8'h22);

        a0 = aerr_cnt; w0 = wstb_cnt;
        issue(1'b1, 20, 0);
        chk("err_addrerr", AddrError, 1);
        chk("err_wrready", WrReady, 0);
        wait_done("err", 0);
        chk("err_pulse", aerr_cnt - a0, 1);
        chk("err_no_write", wstb_cnt - w0, 0);

        wq.delete();
        for (int i = 0; i < 17; i++) wq.push_back(8'(8'h40 + i));
        w0 = wstb_cnt;
        write_burst(0, 31);
        wait_done("sat", 17 * WR_CYC);
        chk("sat_write_count", wstb_cnt - w0, 17);
        for (int i = 0; i < 17; i++) chk("sat_mem", mem[i], 8'(8'h40 + i));

        exp_rd.push_back(8'h43);
        RdReady = 1'b0;
        issue(1'b0, 3, 2);
        tick(); tick();
        chk("rst_mid_rdvalid_before", RdValid, 1);
        tick();
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("rst_mid_rdvalid", RdValid, 0);
        chk("rst_mid_cmdready", CmdReady, 1);
        chk("rst_mid_rddata", RdData, 0);
        chk("rst_mid_addr", MemAddress, 0);
        exp_rd.delete();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_no_done", done_cnt - d0, 0);
        exp_rd.push_back(8'h50); exp_rd.push_back(8'h40);
        read_burst(16, 1, -1, 0);
        wait_done("rd_after_rst", 6);

        corrupt = 1'b1;
        wq = '{8'h01, 8'h02, 8'h03};
        write_burst(6, 2);
        wait_done("vfy", 3 * WR_CYC);
        corrupt = 1'b0;
        chk("vfy_mem7", mem[7], 8'hFD);
        chk("vfy_flag", VerifyError, VFY_EXP);
        tick(); tick();
        chk("vfy_sticky", VerifyError, VFY_EXP);
        RdReady = 1'b1;
        exp_rd.push_back(8'h01);
        issue(1'b0, 6, 0);
        chk("vfy_cleared", VerifyError, 0);
        wait_done("vfy_rd", 3);

        tick();
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
